// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared UART constants and scheduler state encoding    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam int DBITS     = 8;
  localparam int SB_TICK   = 16;
  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD_RATE = 115_200;
  localparam int BAUD_DIV  = CLK_HZ / (BAUD_RATE * SB_TICK);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_e;

  // Index width that stays legal for a single-element range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | byte_fifo : synchronous count-based FIFO, DEPTH a power of 2 >= 2|
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module byte_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             ready
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign ready    = (count_q < C_DEPTH);
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && ready;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_scheduler : round-robin byte arbiter feeding one UART TX |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
module uart_tx_scheduler #(
  parameter int DBITS      = uart_pkg::DBITS,
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16384
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [NREQ*DBITS-1:0]                  req_data,
  output logic [NREQ-1:0]                        req_ready,
  output logic                                   tx_start,
  output logic [DBITS-1:0]                       tx_data,
  input  logic                                   tx_done,
  output logic [uart_pkg::clog2_min1(NREQ)-1:0]  grant_id,
  output logic                                   busy,
  output logic                                   timeout_err,
  output logic                                   spurious_err
);

  import uart_pkg::*;

  localparam int GW = clog2_min1(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] C_TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] C_LAST_RST = GW'(NREQ - 1);

  logic [NREQ-1:0]  fifo_empty;
  logic [NREQ-1:0]  fifo_ready;
  logic [NREQ-1:0]  fifo_pop;
  logic [DBITS-1:0] fifo_rdata [NREQ];

  sched_state_e     state_q, state_d;
  logic [DBITS-1:0] tx_data_q, tx_data_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_grant_q, last_grant_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             spurious_err_q, spurious_err_d;

  logic             sel_found;
  logic [GW-1:0]    sel_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    byte_fifo #(
      .WIDTH (DBITS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (req_valid[gi]),
      .push_data (req_data[gi*DBITS +: DBITS]),
      .pop       (fifo_pop[gi]),
      .pop_data  (fifo_rdata[gi]),
      .empty     (fifo_empty[gi]),
      .ready     (fifo_ready[gi])
    );
  end

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!sel_found && !fifo_empty[GW'((int'(last_grant_q) + k) % NREQ)]) begin
        sel_found = 1'b1;
        sel_idx   = GW'((int'(last_grant_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    tx_data_d      = tx_data_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    tmo_cnt_d      = tmo_cnt_q;
    timeout_err_d  = timeout_err_q;
    spurious_err_d = spurious_err_q || (tx_done && (state_q != ST_WAIT_DONE));
    fifo_pop       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          fifo_pop[sel_idx] = 1'b1;
          tx_data_d         = fifo_rdata[sel_idx];
          grant_d           = sel_idx;
          last_grant_d      = sel_idx;
          state_d           = ST_START;
        end
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_GAP;
        end else if (tmo_cnt_q == C_TMO_MAX) begin
          timeout_err_d = 1'b1;
          state_d       = ST_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      tx_data_q      <= '0;
      grant_q        <= '0;
      last_grant_q   <= C_LAST_RST;
      tmo_cnt_q      <= '0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_data_q      <= tx_data_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
    end
  end

  assign req_ready    = fifo_ready;
  assign tx_start     = (state_q == ST_START);
  assign busy         = (state_q != ST_IDLE);
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_q;
  assign timeout_err  = timeout_err_q;
  assign spurious_err = spurious_err_q;

endmodule
`default_nettype wire
